// File: rtl/video_timing_decoder_if.sv
// Timing-source side and decoded-timing side of the video timing decoder.
// The master drives the pixel enable and sync/blank levels and observes the
// recovered coordinates and measurements; the slave is the decoder itself.
interface video_timing_decoder_if;
  logic       clk_pix;
  logic       hsync;
  logic       vsync;
  logic       hbl;
  logic       vbl;
  logic [8:0] x;
  logic [8:0] y;
  logic       de;
  logic [9:0] htotal;
  logic [9:0] vtotal;
  logic [9:0] hactive;
  logic [9:0] vactive;
  logic       new_frame;
  logic       locked;

  modport master (
    output clk_pix, hsync, vsync, hbl, vbl,
    input  x, y, de, htotal, vtotal, hactive, vactive, new_frame, locked
  );

  modport slave (
    input  clk_pix, hsync, vsync, hbl, vbl,
    output x, y, de, htotal, vtotal, hactive, vactive, new_frame, locked
  );
endinterface

// File: rtl/video_timing_decoder.sv
// Video timing decoder: recovers active-area coordinates, line/frame periods,
// active sizes and a lock flag from sampled hsync/vsync/hbl/vbl levels.
// All state advances only on pixel-enable ticks; new_frame is a single-clk pulse.
module video_timing_decoder (
  input logic                   clk,
  input logic                   reset,
  video_timing_decoder_if.slave vt
);

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // Edge history (previous tick's input levels)
  logic hs_q, vs_q, hbl_q, vbl_q;

  // Counters and measurement registers
  logic [9:0] hcnt, vcnt;
  logic [9:0] htotal_r, vtotal_r, hactive_r, vactive_r;
  logic [8:0] x_r, y_r;
  logic       de_r, new_frame_r, locked_r;
  logic       first_line, line_ok;

  logic       tick;
  logic       hs_rise, vs_rise, hbl_fall, hbl_rise, vbl_fall, vbl_rise;
  logic [9:0] hcnt_nx, vcnt_nx, vtotal_nx;
  logic       line_ok_nx, lock_cond, sat_hit;

  assign tick     = vt.clk_pix;
  assign hs_rise  = vt.hsync & ~hs_q;
  assign vs_rise  = vt.vsync & ~vs_q;
  assign hbl_fall = ~vt.hbl & hbl_q;
  assign hbl_rise = vt.hbl & ~hbl_q;
  assign vbl_fall = ~vt.vbl & vbl_q;
  assign vbl_rise = vt.vbl & ~vbl_q;

  // Next-state of the period counters and the frame lock decision
  always_comb begin
    hcnt_nx    = hs_rise ? 10'd0 : sat_inc10(hcnt);
    vcnt_nx    = vcnt;
    if (vs_rise)
      vcnt_nx = 10'd0;
    else if (hs_rise)
      vcnt_nx = sat_inc10(vcnt);
    // A line closing on the same tick as the frame belongs to the closing frame.
    vtotal_nx  = vcnt + {9'd0, hs_rise};
    line_ok_nx = line_ok & ~(hs_rise & ((hcnt + 10'd1) != htotal_r));
    lock_cond  = line_ok_nx & (vtotal_nx == vtotal_r) &
                 (hcnt != CNT_MAX) & (vcnt != CNT_MAX);
    sat_hit    = (hcnt_nx == CNT_MAX) | (vcnt_nx == CNT_MAX);
  end

  // Tick-qualified timing recovery state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hbl_q       <= 1'b1;
      vbl_q       <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      htotal_r    <= '0;
      vtotal_r    <= '0;
      hactive_r   <= '0;
      vactive_r   <= '0;
      x_r         <= '0;
      y_r         <= '0;
      de_r        <= 1'b0;
      new_frame_r <= 1'b0;
      locked_r    <= 1'b0;
      first_line  <= 1'b0;
      line_ok     <= 1'b1;
    end else begin
      new_frame_r <= tick & vs_rise;
      if (tick) begin
        hs_q  <= vt.hsync;
        vs_q  <= vt.vsync;
        hbl_q <= vt.hbl;
        vbl_q <= vt.vbl;

        hcnt <= hcnt_nx;
        if (hs_rise)
          htotal_r <= hcnt + 10'd1;

        vcnt <= vcnt_nx;
        if (vs_rise)
          vtotal_r <= vtotal_nx;

        de_r <= ~vt.hbl & ~vt.vbl;
        if (!vt.hbl)
          x_r <= hbl_q ? 9'd0 : sat_inc9(x_r);
        if (hbl_rise)
          hactive_r <= {1'b0, x_r} + 10'd1;

        // The active-line check after this may clear first_line on the same tick.
        if (vbl_fall)
          first_line <= 1'b1;
        if (hbl_fall && !vt.vbl) begin
          if (first_line || vbl_fall) begin
            y_r        <= 9'd0;
            first_line <= 1'b0;
          end else begin
            y_r <= sat_inc9(y_r);
          end
        end
        // first_line still set means no active line since the blank ended.
        if (vbl_rise)
          vactive_r <= first_line ? 10'd0 : ({1'b0, y_r} + 10'd1);

        line_ok <= vs_rise ? 1'b1 : line_ok_nx;
        if (sat_hit)
          locked_r <= 1'b0;
        else if (vs_rise)
          locked_r <= lock_cond;
      end
    end
  end

  assign vt.x         = x_r;
  assign vt.y         = y_r;
  assign vt.de        = de_r;
  assign vt.htotal    = htotal_r;
  assign vt.vtotal    = vtotal_r;
  assign vt.hactive   = hactive_r;
  assign vt.vactive   = vactive_r;
  assign vt.new_frame = new_frame_r;
  assign vt.locked    = locked_r;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder: a programmable timing source walks
// (line, column) positions one tick per clk; checks use hand-computed values.
module tb_video_timing_decoder;

  logic clk = 1'b0;
  logic reset;

  video_timing_decoder_if vif();

  video_timing_decoder dut (
    .clk   (clk),
    .reset (reset),
    .vt    (vif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Timing source mode (inclusive, wrap-around ranges)
  int htot, hbl_s, hbl_e, hs_s, hs_e;
  int vtot, vbl_s, vbl_e, vs_s, vs_e;
  int long_v, long_len;
  bit hs_stuck;
  int cur_h, cur_v, last_h, last_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input int p, input int a, input int b);
    return (a <= b) ? (p >= a && p <= b) : (p >= a || p <= b);
  endfunction

  task automatic set_mode(input int ht, input int hbs, input int hbe, input int hss, input int hse,
                          input int vtt, input int vbs, input int vbe, input int vss, input int vse);
    htot = ht; hbl_s = hbs; hbl_e = hbe; hs_s = hss; hs_e = hse;
    vtot = vtt; vbl_s = vbs; vbl_e = vbe; vs_s = vss; vs_e = vse;
  endtask

  task automatic drive(input int h, input int v);
    vif.hsync = hs_stuck ? 1'b0 : in_rng(h, hs_s, hs_e);
    vif.vsync = in_rng(v, vs_s, vs_e);
    vif.hbl   = in_rng(h, hbl_s, hbl_e);
    vif.vbl   = in_rng(v, vbl_s, vbl_e);
  endtask

  task automatic step();
    int len;
    @(negedge clk);
    drive(cur_h, cur_v);
    vif.clk_pix = 1'b1;
    @(posedge clk);
    #1;
    last_h = cur_h;
    last_v = cur_v;
    len = (cur_v == long_v) ? long_len : htot;
    cur_h++;
    if (cur_h >= len) begin
      cur_h = 0;
      cur_v++;
      if (cur_v >= vtot) cur_v = 0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    vif.clk_pix = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int v, input int h);
    for (int i = 0; i < 20000; i++) begin
      step();
      if (last_v == v && last_h == h) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL run_to(%0d,%0d): position not reached, at (%0d,%0d)", v, h, last_v, last_h);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    set_mode(12, 8, 1, 9, 10, 263, 256, 15, 0, 7);
    long_v = -1; long_len = 0; hs_stuck = 1'b0;
    cur_h = 0; cur_v = 0; last_h = 0; last_v = 0;
    reset = 1'b1;
    vif.clk_pix = 1'b0;
    drive(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", vif.x, 0);
    chk("rst_y", vif.y, 0);
    chk("rst_de", vif.de, 0);
    chk("rst_htotal", vif.htotal, 0);
    chk("rst_vtotal", vif.vtotal, 0);
    chk("rst_hactive", vif.hactive, 0);
    chk("rst_vactive", vif.vactive, 0);
    chk("rst_new_frame", vif.new_frame, 0);
    chk("rst_locked", vif.locked, 0);
    @(negedge clk);
    reset = 1'b0;

    // Narrow-line source, 263 lines, 240 active
    run_to(16, 2);
    chk("first_px_x", vif.x, 0);
    chk("first_px_y", vif.y, 0);
    chk("first_px_de", vif.de, 1);
    idle();
    idle();
    chk("freeze_x", vif.x, 0);
    run_to(16, 3);
    chk("second_px_x", vif.x, 1);
    run_to(255, 7);
    chk("last_px_x", vif.x, 5);
    chk("last_px_y", vif.y, 239);
    chk("last_px_de", vif.de, 1);
    run_to(256, 0);
    chk("s_vactive", vif.vactive, 240);
    chk("s_hactive", vif.hactive, 6);
    chk("s_htotal", vif.htotal, 12);
    chk("s_blank_de", vif.de, 0);
    run_to(0, 0);
    chk("vs1_new_frame", vif.new_frame, 1);
    chk("vs1_vtotal", vif.vtotal, 263);
    chk("vs1_locked", vif.locked, 0);
    run_to(0, 0);
    chk("vs2_vtotal", vif.vtotal, 263);
    chk("vs2_locked", vif.locked, 1);
    chk("vs2_new_frame", vif.new_frame, 1);
    idle();
    chk("nf_no_tick", vif.new_frame, 0);
    step();
    chk("nf_next_tick", vif.new_frame, 0);

    // Switch to 387-tick lines, 320 active, 10-line frames
    run_to(262, 11);
    set_mode(387, 336, 15, 344, 375, 10, 8, 1, 0, 0);
    cur_h = 0; cur_v = 0;
    run_to(0, 0);
    chk("w_switch_locked", vif.locked, 1);
    run_to(2, 16);
    chk("w_first_x", vif.x, 0);
    chk("w_first_y", vif.y, 0);
    chk("w_first_de", vif.de, 1);
    run_to(7, 335);
    chk("w_last_x", vif.x, 319);
    chk("w_last_y", vif.y, 5);
    run_to(8, 0);
    chk("w_htotal", vif.htotal, 387);
    chk("w_hactive", vif.hactive, 320);
    chk("w_vactive", vif.vactive, 6);
    run_to(0, 0);
    chk("w_vs1_locked", vif.locked, 0);
    chk("w_vs1_vtotal", vif.vtotal, 10);
    run_to(0, 0);
    chk("w_vs2_locked", vif.locked, 1);

    // 288-wide active area, same sync timing
    run_to(9, 386);
    hbl_s = 320; hbl_e = 31;
    run_to(7, 319);
    chk("n_last_x", vif.x, 287);
    chk("n_last_y", vif.y, 5);
    run_to(8, 0);
    chk("n_hactive", vif.hactive, 288);
    chk("n_vactive", vif.vactive, 6);
    chk("n_locked", vif.locked, 1);

    // One 390-tick line
    long_v = 4; long_len = 390;
    run_to(5, 344);
    chk("long_htotal", vif.htotal, 390);
    chk("long_locked_hold", vif.locked, 1);
    long_v = -1;
    run_to(6, 344);
    chk("long_after_htotal", vif.htotal, 387);
    run_to(0, 0);
    chk("long_vs_locked", vif.locked, 0);
    run_to(0, 0);
    chk("long_relock", vif.locked, 1);

    // Narrow lines again, 224 active lines
    run_to(9, 386);
    set_mode(12, 8, 1, 9, 10, 263, 240, 15, 0, 7);
    cur_h = 0; cur_v = 0;
    run_to(240, 0);
    chk("m_vactive", vif.vactive, 224);
    chk("m_hactive", vif.hactive, 6);
    run_to(0, 0);
    chk("m_vs1_locked", vif.locked, 0);
    chk("m_vs1_vtotal", vif.vtotal, 263);
    run_to(0, 0);
    chk("m_vs2_locked", vif.locked, 1);

    // Reset mid-frame while vsync is high
    run_to(3, 5);
    #2 reset = 1'b1;
    #1;
    chk("mrst_x", vif.x, 0);
    chk("mrst_y", vif.y, 0);
    chk("mrst_de", vif.de, 0);
    chk("mrst_htotal", vif.htotal, 0);
    chk("mrst_vtotal", vif.vtotal, 0);
    chk("mrst_hactive", vif.hactive, 0);
    chk("mrst_vactive", vif.vactive, 0);
    chk("mrst_locked", vif.locked, 0);
    idle();
    chk("mrst_new_frame", vif.new_frame, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rel_new_frame", vif.new_frame, 0);
    run_to(0, 0);
    chk("rel_vs1_nf", vif.new_frame, 1);
    chk("rel_vs1_vtotal", vif.vtotal, 260);
    chk("rel_vs1_locked", vif.locked, 0);
    run_to(0, 0);
    chk("rel_vs2_vtotal", vif.vtotal, 263);
    chk("rel_vs2_locked", vif.locked, 0);
    run_to(0, 0);
    chk("rel_vs3_locked", vif.locked, 1);

    // hsync stuck low until the line counter saturates
    hs_stuck = 1'b1;
    run_n(1019);
    chk("stuck_pre_locked", vif.locked, 1);
    run_n(1);
    chk("stuck_sat_locked", vif.locked, 0);
    run_n(80);
    chk("stuck_htotal", vif.htotal, 12);
    chk("stuck_locked_hold", vif.locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
